rx_fifo_ctrl: RTL and testbench

RX_FIFO_CTRL -- requirements
Module: rx_fifo_ctrl

---
 rtl/uart_fifo_pkg.sv | 16 +
 rtl/rx_pattern_chk.sv | 34 +++
 rtl/rx_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_rx_fifo_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART-to-FIFO receive path: frame length default,
// counter widths and the one-hot state encoding of rx_fifo_ctrl.
package uart_fifo_pkg;

  localparam int FRAME_LEN_DEF = 256;
  localparam int CNT_W         = 9;
  localparam int ERR_W         = 9;

  typedef enum logic [3:0] {
    ST_FILL  = 4'b0001,
    ST_DRAIN = 4'b0010,
    ST_FLUSH = 4'b0100,
    ST_DONE  = 4'b1000
  } rx_state_e;

endpackage

// File: rtl/rx_pattern_chk.sv
// Incrementing-pattern checker: every qualified byte is compared against a
// running expected value (starts at 0, +1 per byte, wraps at 2^DATA_W).
// Mismatches are counted in a saturating error counter.
module rx_pattern_chk
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              clr,
  input  logic              vld,
  input  logic [DATA_W-1:0] data,
  output logic [ERR_W-1:0]  err_cnt
);

  logic [DATA_W-1:0] exp_q;

  // Track the expected byte and count mismatches, saturating at all-ones.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      exp_q   <= '0;
      err_cnt <= '0;
    end else if (clr) begin
      exp_q   <= '0;
      err_cnt <= '0;
    end else if (vld) begin
      exp_q <= exp_q + DATA_W'(1);
      if (data != exp_q && err_cnt != '1)
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: rtl/rx_fifo_ctrl.sv
// Receive FIFO controller: fills a FIFO with FRAME_LEN bytes from the UART,
// then drains the whole frame out to the logic-analyser port and parks in DONE
// until restart. Bytes arriving when they cannot be stored set a sticky
// overflow flag.
// Optional feature: define RX_PATTERN_CHECK_EN to add the incrementing-pattern
// checker on the drained stream; otherwise err_cnt is tied to zero.
module rx_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DATA_W    = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] uart_dout,
  input  logic              uart_done,
  input  logic              restart,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_done,
  output logic              overflow,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] LEN_CNT  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  rx_state_e        state;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             wr_ok;

  // A byte is accepted only in FILL, with room in the FIFO and no restart;
  // the count guard keeps wr_cnt saturating at FRAME_LEN.
  assign wr_ok = (state == ST_FILL) && uart_done && !fifo_full && !restart &&
                 (wr_cnt < LEN_CNT);

  // Read strobe is decoded directly from the current empty flag so it can
  // never be raised in a cycle where the FIFO reports empty.
  assign fifo_rd_en = (state == ST_DRAIN) && !fifo_empty && !restart &&
                      (rd_cnt < LEN_CNT);

  // FIFO read data arrives in the cycle rd_valid is high; forward it then and
  // hold zero otherwise so the port is quiet between bytes and in reset.
  assign rd_data = rd_valid ? fifo_dout : '0;

  // Main control FSM with registered strobes, counters and flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      rd_valid   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else if (restart) begin
      // Restart wins over everything, including a coincident uart_done, and
      // kills any read still in flight.
      state      <= ST_FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      fifo_wr_en <= 1'b0;
      rd_valid   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      fifo_wr_en <= wr_ok;
      if (wr_ok) fifo_din <= uart_dout;
      rd_valid <= fifo_rd_en;
      if (uart_done && !wr_ok) overflow <= 1'b1;
      case (state)
        ST_FILL: begin
          if (wr_ok) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            if (wr_cnt == LAST_CNT) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (rd_cnt == LAST_CNT) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // The only rd_valid seen here belongs to the final read.
          if (rd_valid) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: ;
        default: state <= ST_FILL;
      endcase
    end
  end

`ifdef RX_PATTERN_CHECK_EN
  rx_pattern_chk #(
    .DATA_W (DATA_W)
  ) u_chk (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (restart),
    .vld       (rd_valid),
    .data      (rd_data),
    .err_cnt   (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Directed bench for rx_fifo_ctrl with a behavioural FIFO model. Expected
// err_cnt follows RX_PATTERN_CHECK_EN when the bench is built with it.
module tb_rx_fifo_ctrl;

  localparam int DW = 8;
  localparam int FL = 256;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [DW-1:0] uart_dout = '0;
  logic          uart_done = 1'b0;
  logic          restart = 1'b0;
  logic          fifo_full = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_wr_en, fifo_rd_en, rd_valid, frame_done, overflow;
  logic [DW-1:0] fifo_din, rd_data;
  logic [8:0]    err_cnt;

  logic          force_empty = 1'b0;
  logic          model_empty = 1'b1;
  logic          tog_en = 1'b0;
  int            tcnt = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] expq[$];
  int wr_seen = 0, rd_seen = 0, viol = 0;
  int total = 0, bad = 0;
  int exp_err;

  assign fifo_empty = force_empty | model_empty;

  always #5 sys_clk = ~sys_clk;

  rx_fifo_ctrl #(.FRAME_LEN(FL), .DATA_W(DW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .uart_dout  (uart_dout),
    .uart_done  (uart_done),
    .restart    (restart),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_rd_en (fifo_rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .frame_done (frame_done),
    .overflow   (overflow),
    .err_cnt    (err_cnt)
  );

  // FIFO model plus capture of the drained stream.
  always @(posedge sys_clk) begin
    if (fifo_wr_en) begin
      q.push_back(fifo_din);
      wr_seen++;
    end
    if (fifo_rd_en) begin
      rd_seen++;
      if (fifo_empty) viol++;
      else fifo_dout <= q.pop_front();
    end
    if (rd_valid) got.push_back(rd_data);
    model_empty <= (q.size() == 0);
  end

  // Empty-flag disturbance: toggles every 3 cycles while enabled.
  always @(negedge sys_clk) begin
    if (tog_en) begin
      if (tcnt >= 2) begin
        tcnt        <= 0;
        force_empty <= ~force_empty;
      end else tcnt <= tcnt + 1;
    end else begin
      tcnt        <= 0;
      force_empty <= 1'b0;
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    @(negedge sys_clk);
    uart_dout = b;
    uart_done = 1'b1;
    @(negedge sys_clk);
    uart_done = 1'b0;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (!frame_done && n < lim) begin
      @(negedge sys_clk);
      n++;
    end
    chk(tag, int'(frame_done), 1);
  endtask

  task automatic clear_model();
    q.delete();
    got.delete();
    expq.delete();
    wr_seen = 0;
    rd_seen = 0;
    viol    = 0;
  endtask

  task automatic pulse_restart();
    @(negedge sys_clk);
    restart = 1'b1;
    @(negedge sys_clk);
    restart = 1'b0;
    clear_model();
  endtask

  task automatic chk_stream(input string tag);
    int nmis = 0;
    chk({tag, "_len"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i] !== expq[i]) nmis++;
    chk({tag, "_order"}, nmis, 0);
  endtask

  initial begin
`ifdef RX_PATTERN_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_din", int'(fifo_din), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_err", int'(err_cnt), 0);
    sys_rst_n = 1'b1;

    // Basic frame 0x00..0xFF
    for (int i = 0; i < FL; i++) begin
      send_byte(DW'(i));
      expq.push_back(DW'(i));
    end
    wait_done("t1_done", 2000);
    @(negedge sys_clk);
    chk("t1_writes", wr_seen, 256);
    chk_stream("t1");
    chk("t1_ovf", int'(overflow), 0);
    chk("t1_err", int'(err_cnt), 0);
    chk("t1_viol", viol, 0);
    // DONE holds with no strobes; a late byte is refused and flagged
    repeat (5) @(negedge sys_clk);
    chk("t1_hold_done", int'(frame_done), 1);
    send_byte(8'h77);
    chk("t1_done_nowrite", wr_seen, 256);
    chk("t1_done_reads", rd_seen, 256);
    chk("t1_done_ovf", int'(overflow), 1);

    // Restart returns to FILL with flags cleared
    pulse_restart();
    chk("rs_done_low", int'(frame_done), 0);
    chk("rs_ovf_clr", int'(overflow), 0);

    // fifo_full during the 5th byte
    for (int i = 0; i < FL; i++) begin
      if (i == 4) fifo_full = 1'b1;
      send_byte(DW'(i));
      fifo_full = 1'b0;
      if (i != 4) expq.push_back(DW'(i));
      if (i == 4) begin
        chk("t2_drop_nowrite", wr_seen, 4);
        chk("t2_drop_ovf", int'(overflow), 1);
      end
    end
    chk("t2_still_fill", rd_seen, 0);
    chk("t2_255_writes", wr_seen, 255);
    send_byte(8'h00);
    expq.push_back(8'h00);
    wait_done("t2_done", 2000);
    @(negedge sys_clk);
    chk("t2_writes", wr_seen, 256);
    chk_stream("t2");
    chk("t2_ovf_sticky", int'(overflow), 1);

    // fifo_empty toggling during the drain
    pulse_restart();
    tog_en = 1'b1;
    for (int i = 0; i < FL; i++) begin
      send_byte(DW'(255 - i));
      expq.push_back(DW'(255 - i));
    end
    wait_done("t3_done", 3000);
    tog_en = 1'b0;
    @(negedge sys_clk);
    chk("t3_viol", viol, 0);
    chk("t3_reads", rd_seen, 256);
    chk_stream("t3");

    // Restart after 100 bytes, coincident with a uart_done
    pulse_restart();
    for (int i = 0; i < 100; i++) begin
      if (i == 20) fifo_full = 1'b1;
      send_byte(DW'(i));
      fifo_full = 1'b0;
    end
    chk("t4_pre_ovf", int'(overflow), 1);
    chk("t4_pre_writes", wr_seen, 99);
    @(negedge sys_clk);
    restart   = 1'b1;
    uart_done = 1'b1;
    uart_dout = 8'h55;
    @(negedge sys_clk);
    restart   = 1'b0;
    uart_done = 1'b0;
    clear_model();
    repeat (3) @(negedge sys_clk);
    chk("t4_coinc_nowrite", wr_seen, 0);
    chk("t4_coinc_ovf", int'(overflow), 0);
    chk("t4_done_low", int'(frame_done), 0);
    for (int i = 0; i < FL; i++) begin
      send_byte(DW'(i));
      expq.push_back(DW'(i));
    end
    wait_done("t4_done", 2000);
    @(negedge sys_clk);
    chk("t4_writes", wr_seen, 256);
    chk_stream("t4");
    chk("t4_ovf", int'(overflow), 0);

    // Corrupted byte 0x37 -> 0xAA
    pulse_restart();
    for (int i = 0; i < FL; i++) begin
      send_byte((i == 8'h37) ? 8'hAA : DW'(i));
      expq.push_back((i == 8'h37) ? 8'hAA : DW'(i));
    end
    wait_done("t5_done", 2000);
    @(negedge sys_clk);
    chk_stream("t5");
    chk("t5_err", int'(err_cnt), exp_err);

    // Asynchronous reset mid-drain
    pulse_restart();
    for (int i = 0; i < FL; i++) send_byte(DW'(i));
    begin
      int n = 0;
      while (rd_seen < 20 && n < 1000) begin
        @(negedge sys_clk);
        n++;
      end
    end
    chk("t6_in_drain", int'(rd_seen >= 20), 1);
    send_byte(8'h99);
    chk("t6_drain_nowrite", wr_seen, 256);
    chk("t6_drain_ovf", int'(overflow), 1);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_ar_rd_en", int'(fifo_rd_en), 0);
    chk("t6_ar_rd_valid", int'(rd_valid), 0);
    chk("t6_ar_rd_data", int'(rd_data), 0);
    chk("t6_ar_wr_en", int'(fifo_wr_en), 0);
    chk("t6_ar_din", int'(fifo_din), 0);
    chk("t6_ar_ovf", int'(overflow), 0);
    chk("t6_ar_done", int'(frame_done), 0);
    chk("t6_ar_err", int'(err_cnt), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < FL; i++) begin
      send_byte(DW'(i ^ 8'h5A));
      expq.push_back(DW'(i ^ 8'h5A));
    end
    wait_done("t6_done", 2000);
    @(negedge sys_clk);
    chk("t6_writes", wr_seen, 256);
    chk_stream("t6");
    chk("t6_ovf", int'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
